mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the CPU instruction-fetch port (read-only) and the data port (read/write).
- Sits between openmips and a unified instruction/data RAM in the SOPC.
- Serialises accesses with a 3-state FSM and applies round-robin priority on conflict.
- Raises stallreq so the pipeline holds while either port waits.

Parameters:
ADDR_W, 32, address width of both ports and the memory
DATA_W, 32, data width
SEL_W, 4, byte-select width (DATA_W/8)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
i_req  in  1  fetch request; held with i_addr until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch data, valid when i_ack, else 0
i_ack  out  1  one-cycle fetch completion
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_sel until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_sel  in  SEL_W  byte enables
d_rdata  out  DATA_W  read data, valid when d_ack, else 0
d_ack  out  1  one-cycle data completion (reads and writes)
stallreq  out  1  (i_req & ~i_ack) | (d_req & ~d_ack), combinational
mem_ce  out  1  memory enable, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  registered
mem_wdata  out  DATA_W  registered
mem_sel  out  SEL_W  registered; all ones for fetch
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_ce

Behaviour:
- States: IDLE, ISSUE, WAIT. Internal flags: owner (0 = inst, 1 = data) and last_owner.
- Reset (rst == 0 at an edge):
  - state = IDLE, last_owner = 1 (inst wins the first conflict).
  - mem_ce, mem_we, mem_addr, mem_wdata, mem_sel = 0.
  - i_ack, d_ack = 0; i_rdata, d_rdata = 0.
  - Reset mid-operation aborts the access with no ack. A pending write already issued in ISSUE is not retracted.
- Arbitration, evaluated in IDLE and WAIT:
  - Candidate set = {inst if i_req, data if d_req}.
  - In WAIT, the owner currently being acked is excluded from the candidate set.
  - If both ports are candidates, grant the port != last_owner.
  - If one port is a candidate, grant it.
  - If none, next state is IDLE.
- On grant, at the clock edge:
  - state <= ISSUE, owner <= granted port, last_owner <= granted port.
  - mem_ce <= 1.
  - mem_* loaded from the granted port. For inst: mem_we = 0, mem_sel = all ones, mem_wdata = 0.
- ISSUE:
  - mem_* held for exactly this cycle.
  - At the edge: mem_ce <= 0, mem_we <= 0, state <= WAIT.
- WAIT:
  - Ack of owner = 1 combinationally; that port's rdata = mem_rdata. For writes, rdata is don't-care and driven as mem_rdata.
  - Arbitration for the next access runs in the same cycle, giving back-to-back alternation.
- Latency:
  - req seen in cycle N (state IDLE) → ISSUE in N+1 → ack in N+2.
  - With both ports continuously requesting, each port completes once every 4 cycles; the memory is busy 2 of every 2 cycles per grant (ISSUE+WAIT chained).
- The requester deasserts or changes its request in the cycle after ack. Dropping req before ack is a protocol violation: the access still completes and the ack is ignored by the requester.
- stallreq is combinational; the same-cycle ack clears it, so the pipeline advances on the ack edge.
- mem_addr, mem_wdata and mem_sel retain their last value outside ISSUE; only mem_ce and mem_we qualify them.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_req=d_req=1 → mem_ce=0, i_ack=d_ack=0, stallreq=1. Release → first grant is inst: mem_addr=i_addr in cycle 1 after release, i_ack in cycle 2.
- Single fetch: i_addr=0x0000_0010, memory returns 0x3401_1100 → mem_ce=1, mem_we=0, mem_sel=4'hF in N+1. i_ack=1 and i_rdata=0x3401_1100 in N+2, stallreq=0 that cycle.
- Data write: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_sel=4'b0011 → mem_we=1 with those values for exactly one cycle. d_ack in N+2. Subsequent read of 0x100 returns the memory's merged word.
- Conflict: i_req and d_req asserted together and held; each requester changes address after each ack → grants alternate inst, data, inst, data. ISSUE occurs every 2 cycles and each ack pulses for one cycle.
- Reset mid-access: assert rst=0 during WAIT of a data read → no d_ack that cycle or later. After release, state is IDLE and the request is re-arbitrated with inst winning the conflict.
- Idle return: a single d_req read completes, then both req=0 → state IDLE, mem_ce stays 0, no spurious ack for 10 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch port
// (read-only) and the data port (read/write). Each access takes an ISSUE
// cycle, where the memory strobes are driven, followed by a WAIT cycle, where
// the read data comes back and the owner is acked. Arbitration for the next
// access runs during WAIT, so the two ports can alternate back to back.
// When both ports ask at once, the one that did not win last time gets the
// grant.

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,

  output logic              stallreq,

  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [SEL_W-1:0]  mem_sel,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Owner encoding: 0 = instruction port, 1 = data port.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  state_t state;
  state_t state_next;
  logic   owner;
  logic   last_owner;
  logic   cand_i;
  logic   cand_d;
  logic   grant_valid;
  logic   grant_owner;
  logic   ack_active;

  // Arbitration: pick the next owner in IDLE or WAIT; the port being acked in WAIT sits out.
  always_comb begin
    cand_i      = i_req && !(state == WAIT && owner == OWNER_INST);
    cand_d      = d_req && !(state == WAIT && owner == OWNER_DATA);
    grant_valid = 1'b0;
    grant_owner = last_owner;
    if (state != ISSUE) begin
      if (cand_i && cand_d) begin
        grant_valid = 1'b1;
        grant_owner = ~last_owner;
      end else if (cand_i) begin
        grant_valid = 1'b1;
        grant_owner = OWNER_INST;
      end else if (cand_d) begin
        grant_valid = 1'b1;
        grant_owner = OWNER_DATA;
      end
    end
  end

  // Next-state logic: a grant always starts an ISSUE, ISSUE always moves to WAIT.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = grant_valid ? ISSUE : IDLE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = grant_valid ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Acks and returned data; the ack is masked while reset is held so an aborted access never completes.
  always_comb begin
    ack_active = rst && (state == WAIT);
    i_ack      = ack_active && (owner == OWNER_INST);
    d_ack      = ack_active && (owner == OWNER_DATA);
    i_rdata    = i_ack ? mem_rdata : '0;
    d_rdata    = d_ack ? mem_rdata : '0;
    stallreq   = (i_req && !i_ack) || (d_req && !d_ack);
  end

  // State register together with owner bookkeeping; last_owner resets to data so the instruction port wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWNER_INST;
      last_owner <= OWNER_DATA;
    end else begin
      state <= state_next;
      if (grant_valid) begin
        owner      <= grant_owner;
        last_owner <= grant_owner;
      end
    end
  end

  // Memory request registers: loaded on grant, strobes dropped after the single ISSUE cycle; address/data/select are kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
    end else if (grant_valid) begin
      mem_ce <= 1'b1;
      if (grant_owner == OWNER_DATA) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_sel   <= d_sel;
      end else begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_sel   <= '1;
      end
    end else begin
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
    end
  end

endmodule
